// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, GF(2^8) xtime helper and InvMixColumns FSM states
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W = 32;
    localparam int AES_NUM_COLS = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_mc_state_t;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/inv_mixcolumn.sv
// inv_mixcolumn: combinational AES InvMixColumns on one 32-bit column (row r at [8r+7:8r])
module inv_mixcolumn
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (genvar i = 0; i < 4; i++) begin : g_mul
        logic [7:0] a, x2, x4, x8;
        assign a = col_in[8*i +: 8];
        assign x2 = xtime(a);
        assign x4 = xtime(x2);
        assign x8 = xtime(x4);
        assign m9[i] = x8 ^ a;
        assign mb[i] = x8 ^ x2 ^ a;
        assign md[i] = x8 ^ x4 ^ a;
        assign me[i] = x8 ^ x4 ^ x2;
    end
    // each output row rotates the 0e/0b/0d/09 coefficient pattern by one
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign col_out[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
endmodule

// File: rtl/inv_mixcolumns_seq.sv
// inv_mixcolumns_seq: iterative InvMixColumns, one column per clock between two valid/ready handshakes
module inv_mixcolumns_seq
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out
);
    inv_mc_state_t state, nxt;
    logic [1:0] col;
    logic [AES_STATE_W-1:0] st;
    logic [AES_COL_W-1:0] col_sel, col_res;

    assign col_sel = st[{col, 5'd0} +: AES_COL_W];
    inv_mixcolumn u_core (.col_in(col_sel), .col_out(col_res));

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign state_out = st;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
              state == BUSY ? (col == 2'd3 ? DONE : BUSY) :
              (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col <= '0;
            st <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid) begin
                st <= state_in;
                col <= '0;
            end else if (state == BUSY) begin
                st[{col, 5'd0} +: AES_COL_W] <= col_res;
                if (col != 2'd3) col <= col + 2'd1;
            end
        end
    end
endmodule

// File: doc/inv_mixcolumns_seq.md
# inv_mixcolumns_seq

Iterative AES InvMixColumns engine for the decryption datapath: it accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock. It uses a combinational `inv_mixcolumn` core and returns the result over a second valid/ready handshake. It is the inverse of the encryption-side MixColumns stage and uses the same state packing, so decryption rounds and CPA leakage traces line up column-for-column with encryption.

## Interface
- No parameters. The state width (128) and column count (4) are fixed package constants.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `state_in` is valid.
- `in_ready`  output  1  engine can accept a state; high only in IDLE.
- `state_in`  input  128  state to transform.
- `out_valid`  output  1  `state_out` holds a finished result.
- `out_ready`  input  1  consumer accepts `state_out`.
- `state_out`  output  128  transformed state; driven directly from the working register.

## Operation
- Packing:
  - Column c occupies `[32c+31:32c]`: column 0 is `[31:0]`, column 3 is `[127:96]`.
  - Within a column, row r is bits `[8r+7:8r]`.
- Per column (a0..a3 in, b0..b3 out), in GF(2^8) modulo 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- All products are built from xtime chains and XORs only. No lookup tables, no multipliers.
- FSM states IDLE, BUSY, DONE; 2-bit column counter `col`; 128-bit working register `st`.
  - IDLE: on `in_valid && in_ready`, load `st <= state_in`, set `col <= 0`, go to BUSY. Otherwise stay.
  - BUSY: each edge replaces column `col` of `st` with `inv_mixcolumn(column col)`. Other columns are untouched.
    - If `col == 3`, go to DONE.
    - Else `col <= col + 1`.
  - DONE: `out_valid = 1`. On `out_ready`, go to IDLE. Otherwise hold with `st` frozen.
- `in_valid` in BUSY or DONE is ignored; no accept occurs and the input is not latched.
- There is no accept in the same cycle as an output handshake. The return to IDLE costs one cycle.
- The counter wraps 3→0 only via the IDLE reload, never in BUSY.
- Reset (async, any state, including mid-BUSY): state IDLE, `col = 0`, `st = 0`, `out_valid = 0`, `state_out = 0`, `in_ready = 1` (combinational from IDLE). A partially transformed state is discarded.

## Timing
- Accept edge E0. Columns 0..3 are written at edges E1..E4.
- `out_valid` rises in the cycle after E4: 4 cycles after acceptance.
- With `out_ready` held high, the output handshake is at E5. `in_ready` is high again after E5.
- Next accept is no earlier than E6: maximum throughput is one state per 6 cycles.
- `state_out` is registered and stable for the whole DONE period.
- `in_ready` and `out_valid` are pure state decodes with no combinational path from inputs.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_STATE_W = 128`, `AES_COL_W = 32`, `AES_NUM_COLS = 4`
  - function `xtime(byte)`: shift left, conditional XOR 0x1B
  - enum `inv_mc_state_t` {IDLE, BUSY, DONE}
- Sub-module `inv_mixcolumn`: purely combinational 32-in/32-out. It is the direct inverse of the existing per-column MixColumns core and is reusable by a future fully parallel `inv_mixcolumns`.
- Top level: FSM, counter, 4:1 column select into the core, column write-back decode.

## Test plan
- Single column, known answer: state_in = {96'h0, 32'hbca14d8e} -> state_out = {96'h0, 32'h455313db}. `out_valid` rises exactly 4 cycles after the accept edge.
- Full state: columns 0..3 = 32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6 -> columns 0..3 = 32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6.
- Round trip: 1000 random states through the existing MixColumns model then this block. Output equals the original. Backpressure:
  - Hold `out_ready = 0` for 10 cycles in DONE: `state_out` and `out_valid` stay stable, `in_ready = 0`.
  - Release: the handshake fires once, then `in_ready = 1` the next cycle.
- Ignore while busy: assert `in_valid` with a second state during BUSY and DONE. No accept occurs, and the first result is unaffected.
- Reset mid-BUSY: drop `rst_n` after E2. All outputs go to 0 immediately (`in_ready = 1`). The next accepted state yields a correct result with no residue from the aborted one.
